fwrisc_fpga_tx_arb: RTL

- Shares the single FPGA `tx` UART pin between two byte-stream requesters.
- Requester 0 is the core's memory-mapped console port; requester 1 is the debug/status reporter.
- Round-robin arbitration between the requesters, plus 8N1 serialisation at a fixed clock divider.
- Sits inside fwrisc_fpga_top between the system-bus peripherals and the `tx` output.

---
 rtl/fwrisc_fpga_tx_pkg.sv | 15 +
 rtl/fwrisc_uart_tx_ser.sv | 106 ++++++++++
 rtl/fwrisc_fpga_tx_arb.sv | 61 ++++++
 3 files changed

// File: rtl/fwrisc_fpga_tx_pkg.sv
// Shared types for the FPGA UART transmit path.
// FSM encoding and frame constants.
package fwrisc_fpga_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic IDLE_LEVEL      = 1'b1;

endpackage

// File: rtl/fwrisc_uart_tx_ser.sv
// 8N1 serialiser: divider, shift register and frame FSM.
// tx/busy are registered from the next-state values.
module fwrisc_uart_tx_ser
  import fwrisc_fpga_tx_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       valid,
  input  logic [FRAME_DATA_BITS-1:0] data,
  output logic                       ready,
  output logic                       tx,
  output logic                       busy
);

  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX =
    DW'(CLK_DIV - 1);
  localparam logic [2:0] DATA_LAST =
    3'(FRAME_DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST =
    3'(STOP_BITS - 1);

  tx_state_e state, state_nxt;
  logic [DW-1:0] div, div_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [FRAME_DATA_BITS-1:0] sr, sr_nxt;
  logic tx_nxt, busy_nxt;
  logic tick, hs;

  assign ready = (state == IDLE) && !reset;
  assign hs    = valid && ready;
  assign tick  = (div == DIV_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      div   <= '0;
      cnt   <= '0;
      sr    <= '0;
      tx    <= IDLE_LEVEL;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      div   <= div_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
      tx    <= tx_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    div_nxt   = tick ? '0 : div + 1'b1;
    unique case (state)
      IDLE: begin
        div_nxt = '0;
        if (hs) begin
          state_nxt = START;
          sr_nxt    = data;
        end
      end
      START: begin
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        // 3-bit counter wraps 7->0 as it leaves DATA
        if (tick) begin
          sr_nxt  = sr >> 1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == DATA_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (cnt == STOP_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_nxt   = IDLE_LEVEL;
    busy_nxt = 1'b1;
    unique case (state_nxt)
      IDLE:    busy_nxt = 1'b0;
      START:   tx_nxt   = 1'b0;
      DATA:    tx_nxt   = sr_nxt[0];
      STOP:    tx_nxt   = IDLE_LEVEL;
      default: busy_nxt = 1'b0;
    endcase
  end

endmodule

// File: rtl/fwrisc_fpga_tx_arb.sv
// Round-robin share of the tx pin between
// the console port (0) and debug reporter (1).
module fwrisc_fpga_tx_arb
  import fwrisc_fpga_tx_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       last_grant
);

  logic gnt0, gnt1;
  logic ser_valid, ser_ready;
  logic [FRAME_DATA_BITS-1:0] ser_data;

  // on a tie the requester not served last wins
  assign gnt1 = req1_valid &&
                (!req0_valid || !last_grant);
  assign gnt0 = req0_valid && !gnt1;

  assign ser_valid  = gnt0 || gnt1;
  assign ser_data   = gnt1 ? req1_data : req0_data;
  assign req0_ready = ser_ready && gnt0;
  assign req1_ready = ser_ready && gnt1;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else begin
      unique case (1'b1)
        req1_ready: last_grant <= 1'b1;
        req0_ready: last_grant <= 1'b0;
        default:    last_grant <= last_grant;
      endcase
    end
  end

  fwrisc_uart_tx_ser #(
    .CLK_DIV   (CLK_DIV),
    .STOP_BITS (STOP_BITS)
  ) u_ser (
    .clock (clock),
    .reset (reset),
    .valid (ser_valid),
    .data  (ser_data),
    .ready (ser_ready),
    .tx    (tx),
    .busy  (busy)
  );

endmodule
